// File: rtl/hex_seg_pkg.sv
// rtl/hex_seg_pkg.sv - shared types, segment table and decode helper for hex_seg_reader
package hex_seg_pkg;

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} stab_state_e;
   typedef enum logic {COLLECT, HOLD} hs_state_e;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Returns {legal, nibble}; nibble is 0 when the pattern is not in the table.
   function automatic logic [4:0] seg_to_nibble(input logic [6:0] pat);
      logic [4:0] r;
      r = 5'b0;
      for (int i = 0; i < 16; i++) begin
         if (pat == SEG_TABLE[i]) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/hex_seg_reader_stabilizer.sv
// rtl/hex_seg_reader_stabilizer.sv - per-sample stability FSM producing a capture strobe
module seg_stabilizer
   import hex_seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            pat,
   input  logic [NUM_DIGITS-1:0] sel,
   output logic                  cap,
   output logic [6:0]            cap_pat,
   output logic [NUM_DIGITS-1:0] cap_sel
);

   stab_state_e           state_q, state_d;
   logic [6:0]            pat_q, pat_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  one_hot;
   logic                  changed;
   logic                  start;

   // Whenever cap fires the live inputs equal the stored ones (or are about to be stored).
   assign cap_pat = pat;
   assign cap_sel = sel;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      cap     = 1'b0;
      start   = 1'b0;
      one_hot = $onehot(sel);
      changed = (pat != pat_q) || (sel != sel_q);

      case (state_q)
         S_IDLE: begin
            if (one_hot) start = 1'b1;
         end
         S_COUNT: begin
            if (!one_hot) begin
               state_d = S_IDLE;
            end else if (changed) begin
               start = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == 8'(STABLE_CYCLES)) begin
                  cap     = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!one_hot) state_d = S_IDLE;
            else if (changed) start = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // A fresh sample counts as the first of the run; with a threshold of 1 it captures at once.
      if (start) begin
         pat_d = pat;
         sel_d = sel;
         cnt_d = 8'd1;
         if (STABLE_CYCLES == 1) begin
            cap     = 1'b1;
            state_d = S_DONE;
         end else begin
            state_d = S_COUNT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/hex_seg_reader.sv
// rtl/hex_seg_reader.sv - recovers hex digits from a multiplexed 7-segment bus with Valid/Ack output
module hex_seg_reader
   import hex_seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 2,
   parameter int STABLE_CYCLES  = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [6:0]              Seg,
   input  logic [NUM_DIGITS-1:0]   Sel,
   input  logic                    Ack,
   output logic [4*NUM_DIGITS-1:0] Value,
   output logic                    Valid,
   output logic                    Error,
   output logic [NUM_DIGITS-1:0]   ErrDigit
);

   logic [6:0]              pat;
   logic                    cap;
   logic [6:0]              cap_pat;
   logic [NUM_DIGITS-1:0]   cap_sel;
   logic [4:0]              dec;

   hs_state_e               hs_q, hs_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [4*NUM_DIGITS-1:0] value_q, value_d;
   logic [NUM_DIGITS-1:0]   captured_q, captured_d;
   logic                    error_q, error_d;
   logic [NUM_DIGITS-1:0]   err_digit_q, err_digit_d;

   assign pat = SEG_ACTIVE_LOW ? ~Seg : Seg;

   seg_stabilizer #(
      .NUM_DIGITS    (NUM_DIGITS),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_stab (
      .clk     (Clock),
      .rst     (Reset),
      .pat     (pat),
      .sel     (Sel),
      .cap     (cap),
      .cap_pat (cap_pat),
      .cap_sel (cap_sel)
   );

   assign dec = seg_to_nibble(cap_pat);

   always_comb begin
      hs_d        = hs_q;
      digits_d    = digits_q;
      value_d     = value_q;
      captured_d  = captured_q;
      error_d     = error_q;
      err_digit_d = err_digit_q;

      if (hs_q == HOLD && Ack) begin
         captured_d = '0;
         hs_d       = COLLECT;
      end else if (hs_q == COLLECT && (&captured_q)) begin
         value_d = digits_q;
         hs_d    = HOLD;
      end

      // Applied after the Ack clear so a same-cycle capture keeps its captured bit.
      if (cap) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_sel[i]) begin
               if (dec[4]) begin
                  digits_d[4*i +: 4] = dec[3:0];
                  captured_d[i]      = 1'b1;
               end else begin
                  error_d        = 1'b1;
                  err_digit_d[i] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         hs_q        <= COLLECT;
         digits_q    <= '0;
         value_q     <= '0;
         captured_q  <= '0;
         error_q     <= 1'b0;
         err_digit_q <= '0;
      end else begin
         hs_q        <= hs_d;
         digits_q    <= digits_d;
         value_q     <= value_d;
         captured_q  <= captured_d;
         error_q     <= error_d;
         err_digit_q <= err_digit_d;
      end
   end

   assign Value    = value_q;
   assign Valid    = (hs_q == HOLD);
   assign Error    = error_q;
   assign ErrDigit = err_digit_q;

endmodule

// File: tb/tb_hex_seg_reader.sv
// tb/tb_hex_seg_reader.sv - directed self-checking bench for hex_seg_reader
module tb_hex_seg_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg;
   logic [1:0] sel;
   logic       ack;
   logic [7:0] value;
   logic       valid;
   logic       error;
   logic [1:0] err_digit;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   hex_seg_reader #(
      .NUM_DIGITS     (2),
      .STABLE_CYCLES  (4),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .Clock    (clk),
      .Reset    (rst),
      .Seg      (seg),
      .Sel      (sel),
      .Ack      (ack),
      .Value    (value),
      .Valid    (valid),
      .Error    (error),
      .ErrDigit (err_digit)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive an active-high pattern on the active-low bus for n sampled edges.
   task automatic show(input logic [1:0] s, input logic [6:0] lit, input int n);
      sel = s;
      seg = ~lit;
      step(n);
   endtask

   task automatic do_ack();
      sel = 2'b00;
      ack = 1'b1;
      step(1);
      ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; seg = 7'h7F; sel = 2'b00; ack = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
      check("rst_value", value, 8'h00);
      check("rst_valid", valid, 0);
      check("rst_error", error, 0);
      check("rst_errdigit", err_digit, 2'b00);

      // Basic two-digit capture, latency and hold
      show(2'b01, 7'h4F, 4);
      show(2'b10, 7'h66, 4);
      check("t2_valid_latency", valid, 0);
      step(1);
      check("t2_valid", valid, 1);
      check("t2_value", value, 8'h43);
      sel = 2'b00;
      ack = 1'b0;
      step(10);
      check("t2_hold_valid", valid, 1);
      check("t2_hold_value", value, 8'h43);
      do_ack();
      check("t2_ack_valid", valid, 0);
      check("t2_ack_value_kept", value, 8'h43);

      // Unstable pattern restarts the count; non-one-hot select never captures
      show(2'b01, 7'h06, 3);
      show(2'b01, 7'h5B, 4);
      show(2'b11, 7'h5B, 10);
      check("t3_multi_sel_valid", valid, 0);
      show(2'b10, 7'h7F, 4);
      step(1);
      check("t3_valid", valid, 1);
      check("t3_value", value, 8'h82);
      do_ack();

      // Illegal pattern sets sticky error without capturing
      show(2'b10, 7'h00, 4);
      check("t4_error", error, 1);
      check("t4_errdigit", err_digit, 2'b10);
      check("t4_valid", valid, 0);
      show(2'b01, 7'h6D, 4);
      show(2'b10, 7'h77, 4);
      step(1);
      check("t4_valid2", valid, 1);
      check("t4_value", value, 8'hA5);
      check("t4_error_sticky", error, 1);
      check("t4_errdigit_sticky", err_digit, 2'b10);
      do_ack();

      // Reset mid-count discards the partial count and clears sticky error
      show(2'b01, 7'h07, 2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("t5_rst_error", error, 0);
      check("t5_rst_errdigit", err_digit, 2'b00);
      check("t5_rst_value", value, 8'h00);
      step(2);
      show(2'b10, 7'h3F, 4);
      step(1);
      check("t5_no_early_capture", valid, 0);
      show(2'b01, 7'h07, 4);
      step(1);
      check("t5_valid", valid, 1);
      check("t5_value", value, 8'h07);

      // Captures during HOLD do not disturb Value; captured mask rearms only after Ack
      show(2'b01, 7'h6F, 4);
      show(2'b10, 7'h79, 4);
      step(1);
      check("t6_hold_value", value, 8'h07);
      check("t6_hold_valid", valid, 1);
      do_ack();
      check("t6_ack_valid", valid, 0);
      step(3);
      check("t6_mask_cleared", valid, 0);
      show(2'b01, 7'h6F, 4);
      show(2'b10, 7'h79, 4);
      step(1);
      check("t6_valid", valid, 1);
      check("t6_value", value, 8'hE9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
